// File: rtl/instruction_sequencer.sv
// Instruction producer: loadable program memory, PC, valid/ready issue,
// branch resolution from the datapath's taken flag, and halt at an end address.
module instruction_sequencer #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data,
   input  logic [AW-1:0] end_addr,
   input  logic          start,
   input  logic          instr_ready,
   input  logic          branch_taken,
   output logic [7:0]    instruction,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted
);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RESOLVE, HALT} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] pc_nxt;
   logic [AW-1:0] end_r, end_nxt;
   logic [7:0]    mem [2**AW];
   logic          idle_like;
   logic          is_branch;

   // pc + 1 + sign-extended 2-bit offset, wrapping naturally at AW bits
   function automatic logic [AW-1:0] branch_target(input logic [AW-1:0] p,
                                                   input logic [1:0]    off);
      return p + AW'(1) + {{(AW-2){off[1]}}, off};
   endfunction

   assign idle_like = (state == IDLE) || (state == HALT);
   assign is_branch = (instruction[7:6] == 2'b11);

   always_ff @(posedge clk) begin
      if (load_en && idle_like)
         mem[load_addr] <= load_data;
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      end_nxt   = end_r;
      case (state)
         IDLE, HALT: begin
            if (start) begin
               pc_nxt    = '0;
               end_nxt   = end_addr;
               state_nxt = FETCH;
            end
         end
         FETCH: state_nxt = ISSUE;
         ISSUE: begin
            if (instr_ready) begin
               if (is_branch) begin
                  state_nxt = RESOLVE;
               end else if (pc == end_r) begin
                  state_nxt = HALT;
               end else begin
                  pc_nxt    = pc + AW'(1);
                  state_nxt = FETCH;
               end
            end
         end
         RESOLVE: begin
            // A taken branch continues even from the end address
            if (branch_taken) begin
               pc_nxt    = branch_target(pc, instruction[1:0]);
               state_nxt = FETCH;
            end else if (pc == end_r) begin
               state_nxt = HALT;
            end else begin
               pc_nxt    = pc + AW'(1);
               state_nxt = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= '0;
         end_r       <= '0;
         instruction <= 8'h00;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         end_r <= end_nxt;
         if (state == FETCH)
            instruction <= mem[pc];
      end
   end

   assign instr_valid = (state == ISSUE);
   assign busy        = (state == FETCH) || (state == ISSUE) || (state == RESOLVE);
   assign halted      = (state == HALT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: issue timing, stalls, branches,
// PC wrap, load gating and mid-run reset.
module tb_instruction_sequencer;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [7:0]    load_data = '0;
   logic [AW-1:0] end_addr = '0;
   logic          start = 1'b0;
   logic          instr_ready = 1'b1;
   logic          branch_taken = 1'b0;
   logic [7:0]    instruction;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          busy;
   logic          halted;

   int checks = 0;
   int errors = 0;

   instruction_sequencer #(.AW(AW)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .end_addr(end_addr), .start(start),
      .instr_ready(instr_ready), .branch_taken(branch_taken),
      .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
      .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Advance until the given pc is on offer, bounded to 60 cycles
   task automatic wait_issue(input logic [AW-1:0] p, input string tag);
      int n = 0;
      while (!(instr_valid === 1'b1 && pc === p) && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < 60), 32'd1);
   endtask

   initial begin
      // Reset state
      tick();
      do_reset();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_instr", 32'(instruction), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);

      // Straight-line program, ready held high: issue every 2 cycles
      load(4'd0, 8'h12);
      load(4'd1, 8'h45);
      load(4'd2, 8'h0A);
      end_addr    = 4'd2;
      instr_ready = 1'b1;
      do_start();
      chk("t1_fetch_busy", 32'(busy), 32'd1);
      chk("t1_fetch_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("t1_i0_valid", 32'(instr_valid), 32'd1);
      chk("t1_i0_instr", 32'(instruction), 32'h12);
      chk("t1_i0_pc", 32'(pc), 32'd0);
      tick();
      chk("t1_drop_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("t1_i1_instr", 32'(instruction), 32'h45);
      chk("t1_i1_pc", 32'(pc), 32'd1);
      chk("t1_i1_valid", 32'(instr_valid), 32'd1);
      tick();
      tick();
      chk("t1_i2_instr", 32'(instruction), 32'h0A);
      chk("t1_i2_pc", 32'(pc), 32'd2);
      tick();
      chk("t1_halted", 32'(halted), 32'd1);
      chk("t1_halt_busy", 32'(busy), 32'd0);
      chk("t1_halt_pc", 32'(pc), 32'd2);

      // Load in HALT takes effect on restart; stall at pc 1 with ignored load/start
      load(4'd0, 8'h13);
      do_start();
      tick();
      chk("t2_i0_instr", 32'(instruction), 32'h13);
      chk("t2_i0_pc", 32'(pc), 32'd0);
      tick();
      instr_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         load_en   = 1'b1;
         load_addr = 4'd1;
         load_data = 8'hFF;
         start     = 1'b1;
         chk($sformatf("t2_stall%0d_valid", i), 32'(instr_valid), 32'd1);
         chk($sformatf("t2_stall%0d_instr", i), 32'(instruction), 32'h45);
         chk($sformatf("t2_stall%0d_pc", i), 32'(pc), 32'd1);
         tick();
      end
      load_en     = 1'b0;
      start       = 1'b0;
      chk("t2_stall_end_instr", 32'(instruction), 32'h45);
      instr_ready = 1'b1;
      tick();
      chk("t2_after_valid", 32'(instr_valid), 32'd0);
      chk("t2_after_pc", 32'(pc), 32'd2);
      tick();
      chk("t2_i2_instr", 32'(instruction), 32'h0A);
      tick();
      chk("t2_halted", 32'(halted), 32'd1);

      // Branch at 3 (offset -2), taken -> pc 2
      load(4'd3, 8'hC2);
      end_addr     = 4'd5;
      branch_taken = 1'b1;
      do_start();
      wait_issue(4'd1, "t3_w1");
      chk("t3_mem1_kept", 32'(instruction), 32'h45);
      wait_issue(4'd3, "t3_w3");
      chk("t3_br_instr", 32'(instruction), 32'hC2);
      tick();
      chk("t3_resolve_valid", 32'(instr_valid), 32'd0);
      chk("t3_resolve_busy", 32'(busy), 32'd1);
      tick();
      chk("t3_taken_pc", 32'(pc), 32'd2);
      tick();
      chk("t3_target_instr", 32'(instruction), 32'h0A);
      chk("t3_target_valid", 32'(instr_valid), 32'd1);

      // Reset while in ISSUE aborts the instruction
      do_reset();
      chk("t4_rst_valid", 32'(instr_valid), 32'd0);
      chk("t4_rst_pc", 32'(pc), 32'd0);
      chk("t4_rst_busy", 32'(busy), 32'd0);
      chk("t4_rst_halted", 32'(halted), 32'd0);

      // Re-run retained program, branch not taken -> pc 4
      branch_taken = 1'b0;
      do_start();
      tick();
      chk("t5_i0_instr", 32'(instruction), 32'h13);
      wait_issue(4'd3, "t5_w3");
      chk("t5_br_instr", 32'(instruction), 32'hC2);
      tick();
      tick();
      chk("t5_not_taken_pc", 32'(pc), 32'd4);
      do_reset();

      // Branch at 15, offset +1, taken, 15 is the end address -> pc wraps to 1
      for (int i = 0; i < 16; i++) load(4'(i), 8'(8'h10 + i));
      load(4'd15, 8'hC1);
      end_addr     = 4'd15;
      branch_taken = 1'b1;
      do_start();
      wait_issue(4'd15, "t6_w15");
      chk("t6_br_instr", 32'(instruction), 32'hC1);
      tick();
      tick();
      chk("t6_wrap_pc", 32'(pc), 32'd1);
      chk("t6_wrap_busy", 32'(busy), 32'd1);
      do_reset();

      // Skip past end 3 via branch at 2, then non-branch at 15 wraps to 0
      load(4'd15, 8'h33);
      load(4'd2, 8'hC1);
      end_addr = 4'd3;
      do_start();
      wait_issue(4'd2, "t7_w2");
      chk("t7_br_instr", 32'(instruction), 32'hC1);
      tick();
      tick();
      chk("t7_skip_pc", 32'(pc), 32'd4);
      wait_issue(4'd15, "t7_w15");
      chk("t7_i15_instr", 32'(instruction), 32'h33);
      tick();
      chk("t7_wrap_pc", 32'(pc), 32'd0);
      chk("t7_wrap_halted", 32'(halted), 32'd0);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
